rpn_sequencer: RTL and testbench
================================

RPN_SEQUENCER -- requirements
Module: rpn_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: operand, result and display width in bits.
REQ-002 Parameter OPW, default 2: opcode width in bits, taken from data_in[OPW-1:0].
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enter  input  1  debounced level from the Enter button; acts on its rising edge only.
REQ-006 undo  input  1  debounced level from the Undo button; acts on its rising edge only.
REQ-007 data_in  input  WIDTH  switch value: operand or opcode source.
REQ-008 alu_result  input  WIDTH  combinational ALU output for the current op_a, op_b and opcode.
REQ-009 alu_flags  input  4  combinational ALU flags (N,Z,C,V) for the current operands.
REQ-010 op_a, op_b  output  WIDTH each  registered operands driven to the ALU.
REQ-011 opcode  output  OPW  registered operation select driven to the ALU.
REQ-012 display_value  output  WIDTH  value for the 7-segment driver.
REQ-013 flags  output  4  registered flags of the last completed calculation.
REQ-014 status  output  3  current state code.

Function
REQ-015 Edge detection: one registered copy each of enter and undo; an event is a 0->1 transition; a held level produces exactly one event.
REQ-016 States and status codes: S_A=0, S_B=1, S_OP=2, S_CALC=3, S_SHOW=4. Codes 5-7 are unreachable; if entered, the next cycle goes to S_A.
REQ-017 S_A, enter event: op_a<=data_in; next state S_B.
REQ-018 S_B, enter event: op_b<=data_in; next state S_OP.
REQ-019 S_OP, enter event: opcode<=data_in[OPW-1:0]; next state S_CALC.
REQ-020 S_CALC: unconditional one-cycle state. At its end, result<=alu_result and flags<=alu_flags; next state S_SHOW. Latency from the S_OP enter event to the valid result is 2 cycles.
REQ-021 S_CALC ignores all enter and undo events.
REQ-022 Undo in S_A: no effect.
REQ-023 Undo in S_B: op_a<=0; next state S_A.
REQ-024 Undo in S_OP: op_b<=0; next state S_B.
REQ-025 Undo in S_SHOW: op_a, op_b, opcode, result and flags all <=0; next state S_A.
REQ-026 Enter and undo events in the same cycle: undo wins; enter is discarded.
REQ-027 display_value: data_in (live) in S_A, S_B and S_OP; result in S_CALC and S_SHOW.
REQ-028 result is an internal WIDTH-bit register; the block performs no arithmetic.

Reset
REQ-029 reset asserted: state=S_A; op_a, op_b, opcode, result and flags=0; edge registers=0. Takes effect immediately, without waiting for clk.
REQ-030 Reset asserted mid-operation, including in S_CALC, aborts the operation; no result is latched.
REQ-031 Because the edge registers clear to 0, a button held through reset deassertion produces one event on the first clock edge after deassertion.

Configuration
REQ-032 Macro RPN_SEQ_CHAIN_EN defined: enter event in S_SHOW sets op_a<=result, op_b<=0 and opcode<=0; next state S_B (chained calculation).
REQ-033 Macro RPN_SEQ_CHAIN_EN undefined: enter event in S_SHOW clears op_a, op_b, opcode, result and flags to 0; next state S_A.

Verification
REQ-034 Reset, then enter events with data_in=0x0005, 0x0003, 0x0001 (add) and alu_result model A+B -> status 0->1->2->3->4; display_value=0x0008 two cycles after the third event.
REQ-035 In S_OP, undo event -> status=1, op_b=0; then enter with data_in=0x0007 -> op_b=0x0007, status=2.
REQ-036 enter and undo rise in the same cycle in S_B -> status=0, op_a=0, op_b unchanged.
REQ-037 enter held high for 100 cycles in S_A -> exactly one transition, status=1.
REQ-038 reset pulsed asynchronously (between clk edges) in S_CALC -> all outputs 0 and status=0 before the next clk edge; flags stay 0.
REQ-039 In S_SHOW with result=0x0008, enter event -> with RPN_SEQ_CHAIN_EN: op_a=0x0008, status=1; without: op_a=0, status=0.

Source files
------------

// File: rtl/rpn_sequencer.sv
// Operand/opcode entry sequencer for a push-button RPN calculator; drives an external ALU.
// Optional macro RPN_SEQ_CHAIN_EN: enter in S_SHOW feeds the result back as the next op_a.
module rpn_sequencer #(
  parameter int WIDTH = 16,
  parameter int OPW   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic             undo,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [OPW-1:0]   opcode,
  output logic [WIDTH-1:0] display_value,
  output logic [3:0]       flags,
  output logic [2:0]       status
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] op_a_reg, op_a_next;
  logic [WIDTH-1:0] op_b_reg, op_b_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [OPW-1:0]   opcode_reg, opcode_next;
  logic [3:0]       flags_reg, flags_next;
  logic             enter_d_reg, undo_d_reg;
  logic             enter_evt, undo_evt, enter_go;

  assign enter_evt = enter & ~enter_d_reg;
  assign undo_evt  = undo & ~undo_d_reg;
  // Undo has priority over a simultaneous enter.
  assign enter_go  = enter_evt & ~undo_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_A;
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      opcode_reg  <= '0;
      result_reg  <= '0;
      flags_reg   <= '0;
      enter_d_reg <= 1'b0;
      undo_d_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_a_reg    <= op_a_next;
      op_b_reg    <= op_b_next;
      opcode_reg  <= opcode_next;
      result_reg  <= result_next;
      flags_reg   <= flags_next;
      enter_d_reg <= enter;
      undo_d_reg  <= undo;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_a_next   = op_a_reg;
    op_b_next   = op_b_reg;
    opcode_next = opcode_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
    case (state_reg)
      S_A: begin
        if (enter_go) begin
          op_a_next  = data_in;
          state_next = S_B;
        end
      end
      S_B: begin
        if (undo_evt) begin
          op_a_next  = '0;
          state_next = S_A;
        end else if (enter_go) begin
          op_b_next  = data_in;
          state_next = S_OP;
        end
      end
      S_OP: begin
        if (undo_evt) begin
          op_b_next  = '0;
          state_next = S_B;
        end else if (enter_go) begin
          opcode_next = data_in[OPW-1:0];
          state_next  = S_CALC;
        end
      end
      S_CALC: begin
        // ALU has had one full cycle on the registered operands; buttons are ignored here.
        result_next = alu_result;
        flags_next  = alu_flags;
        state_next  = S_SHOW;
      end
      S_SHOW: begin
        if (undo_evt) begin
          op_a_next   = '0;
          op_b_next   = '0;
          opcode_next = '0;
          result_next = '0;
          flags_next  = '0;
          state_next  = S_A;
        end else if (enter_go) begin
`ifdef RPN_SEQ_CHAIN_EN
          op_a_next   = result_reg;
          op_b_next   = '0;
          opcode_next = '0;
          state_next  = S_B;
`else
          op_a_next   = '0;
          op_b_next   = '0;
          opcode_next = '0;
          result_next = '0;
          flags_next  = '0;
          state_next  = S_A;
`endif
        end
      end
      default: state_next = S_A;
    endcase
  end

  assign display_value = (state_reg == S_CALC || state_reg == S_SHOW) ? result_reg : data_in;
  assign op_a          = op_a_reg;
  assign op_b          = op_b_reg;
  assign opcode        = opcode_reg;
  assign flags         = flags_reg;
  assign status        = state_reg;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Randomized scoreboard bench for rpn_sequencer with a transaction-level reference model.
`timescale 1ns/1ps
module tb_rpn_sequencer;

  localparam int WIDTH = 16;
  localparam int OPW   = 2;

  logic             clk = 0;
  logic             reset = 1;
  logic             enter = 0;
  logic             undo = 0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic [WIDTH-1:0] op_a, op_b, display_value;
  logic [OPW-1:0]   opcode;
  logic [3:0]       flags;
  logic [2:0]       status;

  int passed = 0;
  int total  = 0;

  rpn_sequencer #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .reset(reset), .enter(enter), .undo(undo),
    .data_in(data_in), .alu_result(alu_result), .alu_flags(alu_flags),
    .op_a(op_a), .op_b(op_b), .opcode(opcode),
    .display_value(display_value), .flags(flags), .status(status)
  );

  always #5 clk = ~clk;

  // ALU: 0 sub, 1 add, 2 and, 3 xor; returns {N,Z,C,V,result}
  function automatic logic [19:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op);
    logic [16:0] w;
    logic [15:0] r;
    logic        v;
    case (op)
      2'd0:    w = {1'b0, a} - {1'b0, b};
      2'd1:    w = {1'b0, a} + {1'b0, b};
      2'd2:    w = {1'b0, a & b};
      default: w = {1'b0, a ^ b};
    endcase
    r = w[15:0];
    v = (op == 2'd1) ? ((a[15] == b[15]) && (r[15] != a[15])) : 1'b0;
    return {r[15], (r == 16'd0), w[16], v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_f(op_a, op_b, opcode);

  // Reference model: calculator state tracked per button transaction.
  int               m_state;
  logic [15:0]      m_a, m_b, m_res;
  logic [1:0]       m_op;
  logic [3:0]       m_flags;
  logic [19:0]      exp_q[$];

  task automatic model_reset();
    m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0;
    exp_q.delete();
  endtask

  task automatic model_event(input bit en, input bit un, input logic [15:0] v);
    logic [19:0] r;
    if (un) begin
      case (m_state)
        1: begin m_a = 0; m_state = 0; end
        2: begin m_b = 0; m_state = 1; end
        4: begin m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0; m_state = 0; end
        default: ;
      endcase
    end else if (en) begin
      case (m_state)
        0: begin m_a = v; m_state = 1; end
        1: begin m_b = v; m_state = 2; end
        2: begin
          m_op = v[1:0];
          r = alu_f(m_a, m_b, m_op);
          m_res = r[15:0]; m_flags = r[19:16];
          exp_q.push_back(r);
          m_state = 4;
        end
        4: begin
`ifdef RPN_SEQ_CHAIN_EN
          m_a = m_res; m_b = 0; m_op = 0; m_state = 1;
`else
          m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0; m_state = 0;
`endif
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_model();
    chk("status", {29'd0, status}, m_state);
    chk("op_a", {16'd0, op_a}, {16'd0, m_a});
    chk("op_b", {16'd0, op_b}, {16'd0, m_b});
    chk("opcode", {30'd0, opcode}, {30'd0, m_op});
    chk("flags", {28'd0, flags}, {28'd0, m_flags});
    if (m_state == 4) chk("display_result", {16'd0, display_value}, {16'd0, m_res});
    else              chk("display_live", {16'd0, display_value}, {16'd0, data_in});
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_status"}, {29'd0, status}, 0);
    chk({name, "_op_a"}, {16'd0, op_a}, 0);
    chk({name, "_op_b"}, {16'd0, op_b}, 0);
    chk({name, "_opcode"}, {30'd0, opcode}, 0);
    chk({name, "_flags"}, {28'd0, flags}, 0);
  endtask

  // One button transaction; returns two edges later so a calculation has settled.
  task automatic press(input bit en, input bit un, input logic [15:0] v);
    @(negedge clk);
    data_in = v; enter = en; undo = un;
    @(posedge clk); #1;
    enter = 0; undo = 0;
    model_event(en, un, v);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    #1;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  // Monitor: each completed calculation is checked against the scoreboard.
  logic [2:0] prev_status = 3'd0;
  always @(negedge clk) begin
    logic [19:0] e;
    if (!reset && status == 3'd4 && prev_status == 3'd3) begin
      if (exp_q.size() == 0) chk("result_queue_size", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        $display("calc done: result=%h flags=%b", display_value, flags);
        chk("calc_result", {16'd0, display_value}, {16'd0, e[15:0]});
        chk("calc_flags", {28'd0, flags}, {28'd0, e[19:16]});
      end
    end
    prev_status = status;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int changes;
    logic [2:0] last;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset_display", {16'd0, display_value}, {16'd0, data_in});
    @(negedge clk);
    reset = 0;

    // 5 + 3 with status walk and 2-cycle latency
    press(1, 0, 16'h0005); chk_model();
    press(1, 0, 16'h0003); chk_model();
    @(negedge clk);
    data_in = 16'h0001; enter = 1;
    @(posedge clk); #1;
    enter = 0;
    chk("calc_state", {29'd0, status}, 3);
    model_event(1, 0, 16'h0001);
    @(posedge clk); #1;
    chk("add_display", {16'd0, display_value}, 32'h8);
    chk_model();

    // enter in S_SHOW: chain or clear
    press(1, 0, 16'h1234);
    chk_model();
`ifdef RPN_SEQ_CHAIN_EN
    chk("chain_op_a", {16'd0, op_a}, 32'h8);
    chk("chain_status", {29'd0, status}, 1);
`else
    chk("clear_op_a", {16'd0, op_a}, 0);
    chk("clear_status", {29'd0, status}, 0);
`endif

    // undo in S_OP then re-enter op_b
    do_reset();
    press(1, 0, 16'h0005); press(1, 0, 16'h0003);
    press(0, 1, 16'h0000); chk_model();
    chk("undo_op_b", {16'd0, op_b}, 0);
    press(1, 0, 16'h0007); chk_model();
    chk("reenter_op_b", {16'd0, op_b}, 32'h7);

    // enter and undo together in S_B
    do_reset();
    press(1, 0, 16'h0009);
    press(1, 1, 16'h0004); chk_model();

    // undo during S_CALC is ignored
    do_reset();
    press(1, 0, 16'h0002); press(1, 0, 16'h0003);
    @(negedge clk);
    data_in = 16'h0001; enter = 1;
    @(posedge clk); #1;
    enter = 0;
    model_event(1, 0, 16'h0001);
    @(negedge clk);
    undo = 1;
    @(posedge clk); #1;
    undo = 0;
    @(posedge clk); #1;
    chk_model();

    // asynchronous reset inside S_CALC
    do_reset();
    press(1, 0, 16'h0011); press(1, 0, 16'h0022);
    @(negedge clk);
    data_in = 16'h0001; enter = 1;
    @(posedge clk); #1;
    enter = 0;
    #2 reset = 1;
    #1;
    chk_zero("async_reset");
    chk("async_reset_display", {16'd0, display_value}, {16'd0, data_in});
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("held_reset");

    // enter held across reset release gives one event
    enter = 1; data_in = 16'h0011;
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    model_event(1, 0, 16'h0011);
    chk_model();
    @(negedge clk);
    enter = 0;

    // enter held 100 cycles in S_A
    do_reset();
    @(negedge clk);
    data_in = 16'h0022; enter = 1;
    changes = 0;
    last = status;
    repeat (100) begin
      @(posedge clk); #1;
      if (status != last) changes++;
      last = status;
    end
    enter = 0;
    model_event(1, 0, 16'h0022);
    chk("held_enter_transitions", changes, 1);
    chk_model();

    // randomized transactions
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int r;
      bit en, un;
      r  = $urandom_range(0, 9);
      en = (r < 6) || (r == 9);
      un = (r >= 6);
      press(en, un, 16'($urandom));
      chk_model();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
